// File: rtl/register_file_scoreboard.sv
// Parametrised multi-read/single-write register file with write-through bypass,
// hardwired-zero register 0 and a per-register pending scoreboard for decode stalls.
module register_file_scoreboard #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned NUM_READ_PORTS = 2
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 wr_en,
  input  logic [ADDR_WIDTH-1:0]                wr_addr,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  input  logic                                 rsv_en,
  input  logic [ADDR_WIDTH-1:0]                rsv_addr,
  input  logic                                 flush,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ_PORTS-1:0]            rd_busy,
  output logic [ADDR_WIDTH:0]                  busy_count
);

  localparam int unsigned NUM_REGS  = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   pending_q;
  logic [NUM_REGS-1:0]   pending_d;
  logic [CNT_WIDTH-1:0]  count_d;
  logic                  wr_hit;
  logic                  rsv_hit;

  // Register 0 never takes part in writes, bypass or reservations.
  assign wr_hit  = wr_en  && (wr_addr  != '0);
  assign rsv_hit = rsv_en && (rsv_addr != '0);

  // Storage; the data write happens even in a flush cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_hit) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Next pending vector: flush dominates, and a same-address reserve beats the writeback clear.
  always_comb begin
    pending_d = pending_q;
    count_d   = '0;
    if (flush) begin
      pending_d = '0;
    end else begin
      if (wr_hit) begin
        pending_d[wr_addr] = 1'b0;
      end
      if (rsv_hit) begin
        pending_d[rsv_addr] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      count_d = count_d + CNT_WIDTH'(pending_d[i]);
    end
  end

  // Pending bits and their population count move on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      busy_count <= '0;
    end else begin
      pending_q  <= pending_d;
      busy_count <= count_d;
    end
  end

  // Read ports; reset forces zero data and no busy, even on a bypass hit.
  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic                  bypass;

    assign addr   = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign bypass = wr_hit && (wr_addr == addr);

    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = !reset_n ? '0
                                               : bypass   ? wr_data
                                               :            regs_q[addr];
    assign rd_busy[p] = reset_n && pending_q[addr] && !bypass;
  end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Self-checking bench: directed vector table, async-reset sequence, scoreboard fill,
// then randomised traffic checked against a behavioural model through an expectation queue.
module tb_register_file_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        flush;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [5:0]  busy_count;

  register_file_scoreboard #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (5),
    .NUM_READ_PORTS(2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .flush     (flush),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic        fl;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic [5:0]  cnt;
  } vec_t;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic [5:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_pend;
  logic [4:0]  pool [4];

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic re, input logic [4:0] ra, input logic fl,
                              input logic [4:0] a0, input logic [4:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [1:0] busy, input logic [5:0] cnt);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.fl = fl;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.busy = busy; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, want);
    end
  endtask

  // Drive one cycle's inputs, queue the expectation, then compare before the next edge.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    wr_en    = v.we;
    wr_addr  = v.wa;
    wr_data  = v.wd;
    rsv_en   = v.re;
    rsv_addr = v.ra;
    flush    = v.fl;
    rd_addr  = {v.a1, v.a0};
    exp_q.push_back('{d0: v.d0, d1: v.d1, busy: v.busy, cnt: v.cnt});
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL queue_empty step %0d: got 0 entries expected 1", idx);
    end else begin
      e = exp_q.pop_front();
      check("rd_data0",   idx, rd_data[31:0],       e.d0);
      check("rd_data1",   idx, rd_data[63:32],      e.d1);
      check("rd_busy",    idx, 32'(rd_busy),        32'(e.busy));
      check("busy_count", idx, 32'(busy_count),     32'(e.cnt));
    end
  endtask

  function automatic logic [5:0] model_count();
    logic [5:0] c = '0;
    for (int i = 0; i < 32; i++) c = c + 6'(m_pend[i]);
    return c;
  endfunction

  // Expected values from the behavioural model, then advance the model past the edge.
  task automatic model_step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                            input logic re, input logic [4:0] ra, input logic fl,
                            input logic [4:0] a0, input logic [4:0] a1, input int idx);
    vec_t v;
    logic whit, b0, b1;
    whit = we && (wa != 5'd0);
    b0   = whit && (wa == a0);
    b1   = whit && (wa == a1);
    v = mk(we, wa, wd, re, ra, fl, a0, a1,
           b0 ? wd : m_regs[a0], b1 ? wd : m_regs[a1],
           {m_pend[a1] && !b1, m_pend[a0] && !b0}, model_count());
    apply(v, idx);
    if (whit) m_regs[wa] = wd;
    if (fl) begin
      m_pend = '0;
    end else begin
      if (whit) m_pend[wa] = 1'b0;
      if (re && ra != 5'd0) m_pend[ra] = 1'b1;
    end
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 2) == 0) return 5'($urandom_range(0, 31));
    return pool[$urandom_range(0, 3)];
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t dir [21];
    dir[0]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 5, 32'h0,        32'h0,        2'b00, 6'd0);
    dir[1]  = mk(1, 7, 32'hDEADBEEF, 0, 0, 0, 7, 0, 32'hDEADBEEF, 32'h0,        2'b00, 6'd0);
    dir[2]  = mk(0, 0, 32'h0,        0, 0, 0, 7, 7, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 6'd0);
    dir[3]  = mk(1, 0, 32'h1234,     1, 0, 0, 0, 0, 32'h0,        32'h0,        2'b00, 6'd0);
    dir[4]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        2'b00, 6'd0);
    dir[5]  = mk(0, 0, 32'h0,        1, 3, 0, 7, 3, 32'hDEADBEEF, 32'h0,        2'b00, 6'd0);
    dir[6]  = mk(0, 0, 32'h0,        1, 4, 0, 4, 3, 32'h0,        32'h0,        2'b10, 6'd1);
    dir[7]  = mk(1, 3, 32'h55,       0, 0, 0, 4, 3, 32'h0,        32'h55,       2'b01, 6'd2);
    dir[8]  = mk(0, 0, 32'h0,        1, 9, 0, 3, 4, 32'h55,       32'h0,        2'b10, 6'd1);
    dir[9]  = mk(1, 9, 32'hA,        1, 9, 0, 9, 4, 32'hA,        32'h0,        2'b10, 6'd2);
    dir[10] = mk(0, 0, 32'h0,        0, 0, 0, 9, 9, 32'hA,        32'hA,        2'b11, 6'd2);
    dir[11] = mk(1, 4, 32'h44,       0, 0, 0, 4, 9, 32'h44,       32'hA,        2'b10, 6'd2);
    dir[12] = mk(1, 5, 32'h77,       0, 0, 0, 5, 4, 32'h77,       32'h44,       2'b00, 6'd1);
    dir[13] = mk(1, 9, 32'hB,        1, 1, 0, 9, 1, 32'hB,        32'h0,        2'b00, 6'd1);
    dir[14] = mk(0, 0, 32'h0,        1, 2, 0, 1, 2, 32'h0,        32'h0,        2'b01, 6'd1);
    dir[15] = mk(0, 0, 32'h0,        1, 3, 0, 3, 9, 32'h55,       32'hB,        2'b00, 6'd2);
    dir[16] = mk(1, 3, 32'h66,       1, 4, 1, 3, 2, 32'h66,       32'h0,        2'b10, 6'd3);
    dir[17] = mk(0, 0, 32'h0,        0, 0, 0, 4, 3, 32'h44,       32'h66,       2'b00, 6'd0);
    dir[18] = mk(0, 0, 32'h0,        1, 1, 0, 1, 2, 32'h0,        32'h0,        2'b00, 6'd0);
    dir[19] = mk(0, 0, 32'h0,        1, 2, 0, 1, 2, 32'h0,        32'h0,        2'b01, 6'd1);
    dir[20] = mk(0, 0, 32'h0,        0, 0, 0, 1, 2, 32'h0,        32'h0,        2'b11, 6'd2);

    pool[0] = 5'd0; pool[1] = 5'd1; pool[2] = 5'd2; pool[3] = 5'd31;

    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    apply(mk(0, 0, 32'h0, 0, 0, 0, 0, 5, 32'h0, 32'h0, 2'b00, 6'd0), 100);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      apply(dir[i], i);
    end

    // Async reset between edges with r1/r2 pending and a write in flight.
    #2;
    reset_n = 1'b0;
    apply(mk(1, 5, 32'h12345678, 0, 0, 0, 1, 7, 32'h0, 32'h0, 2'b00, 6'd0), 21);
    @(negedge clk);
    apply(mk(1, 5, 32'h12345678, 0, 0, 0, 1, 7, 32'h0, 32'h0, 2'b00, 6'd0), 22);
    @(negedge clk);
    reset_n = 1'b1;
    apply(mk(0, 0, 32'h0, 0, 0, 0, 5, 7, 32'h0, 32'h0, 2'b00, 6'd0), 23);

    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pend = '0;

    // Reserve every register to reach the maximum count, then flush.
    for (int a = 1; a < 32; a++) begin
      @(negedge clk);
      model_step(0, 5'd0, 32'h0, 1, 5'(a), 0, 5'(a), 5'(a - 1), 200 + a);
    end
    @(negedge clk);
    model_step(0, 5'd0, 32'h0, 1, 5'd31, 0, 5'd31, 5'd0, 240);
    @(negedge clk);
    model_step(1, 5'd31, 32'hCAFEF00D, 0, 5'd0, 1, 5'd31, 5'd30, 241);
    @(negedge clk);
    model_step(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd31, 5'd30, 242);

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      model_step(1'($urandom_range(0, 1)), rand_addr(), $urandom,
                 1'($urandom_range(0, 1)), rand_addr(),
                 ($urandom_range(0, 15) == 0),
                 rand_addr(), rand_addr(), 300 + i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
